burst_ram_arbiter: RTL

- Two-requester controller in front of BurstRAM: requester 0 (instruction fetch) and requester 1 (data).
- Each request moves one full burst line (BURST_COUNT words of DATA_WIDTH bits), either a read or a masked write.
- The block arbitrates round-robin, issues the command to BurstRAM, and sequences the write beats.
- It collects read beats into a line buffer and returns a one-cycle done pulse to the winner.

---
 rtl/burst_ram_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/burst_ram_arbiter.sv
// Purpose: round-robin front end that moves one full BurstRAM line per request for two requesters.
// Latency: read = cmd cycle + RAM access + BURST_COUNT beats + 1; write = BURST_COUNT beats + busy drain + 1.
// Backpressure: requesters hold valid (and stable inputs) until done; grants wait in IDLE for ram_busy low.
module burst_ram_arbiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_COUNT = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int MASK_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req0_valid,
  input  logic                              req0_write,
  input  logic [ADDR_WIDTH-1:0]             req0_addr,
  input  logic [BURST_COUNT*DATA_WIDTH-1:0] req0_wdata,
  input  logic [BURST_COUNT*MASK_WIDTH-1:0] req0_wmask,
  output logic [BURST_COUNT*DATA_WIDTH-1:0] req0_rdata,
  output logic                              done0,
  input  logic                              req1_valid,
  input  logic                              req1_write,
  input  logic [ADDR_WIDTH-1:0]             req1_addr,
  input  logic [BURST_COUNT*DATA_WIDTH-1:0] req1_wdata,
  input  logic [BURST_COUNT*MASK_WIDTH-1:0] req1_wmask,
  output logic [BURST_COUNT*DATA_WIDTH-1:0] req1_rdata,
  output logic                              done1,
  output logic                              ram_cmd,
  output logic                              ram_cmd_en,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wr_data,
  output logic [MASK_WIDTH-1:0]             ram_data_mask,
  input  logic [DATA_WIDTH-1:0]             ram_rd_data,
  input  logic                              ram_rd_data_valid,
  input  logic                              ram_busy
);

  localparam int BEAT_W = $clog2(BURST_COUNT);
  localparam int LINE_W = BURST_COUNT * DATA_WIDTH;
  localparam int LMSK_W = BURST_COUNT * MASK_WIDTH;
  // Clears the word-within-line bits so every command is line aligned.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BURST_COUNT - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BURST_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_BEAT,
    WR_DRAIN,
    DONE
  } state_t;

  state_t              state;
  logic                ptr;      // preferred requester when both are valid
  logic                winner;   // requester currently being serviced
  logic [BEAT_W-1:0]   beat;
  logic [LINE_W-1:0]   rbuf0;
  logic [LINE_W-1:0]   rbuf1;

  logic                pick;
  logic                sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_W-1:0]   sel_wdata;
  logic [LMSK_W-1:0]   sel_wmask;
  logic [LINE_W-1:0]   cur_wdata;
  logic [LMSK_W-1:0]   cur_wmask;

  assign req0_rdata = rbuf0;
  assign req1_rdata = rbuf1;

  // Arbitration choice for the next grant, and the serviced requester's write line during beats.
  always_comb begin
    pick      = (req0_valid && req1_valid) ? ptr : req1_valid;
    sel_write = pick ? req1_write : req0_write;
    sel_addr  = pick ? req1_addr  : req0_addr;
    sel_wdata = pick ? req1_wdata : req0_wdata;
    sel_wmask = pick ? req1_wmask : req0_wmask;
    cur_wdata = winner ? req1_wdata : req0_wdata;
    cur_wmask = winner ? req1_wmask : req0_wmask;
  end

  // Controller FSM: grant, one-cycle command, write beat sequencing, read beat capture, done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      winner        <= 1'b0;
      beat          <= '0;
      rbuf0         <= '0;
      rbuf1         <= '0;
      ram_cmd       <= 1'b0;
      ram_cmd_en    <= 1'b0;
      ram_addr      <= '0;
      ram_wr_data   <= '0;
      ram_data_mask <= '0;
      done0         <= 1'b0;
      done1         <= 1'b0;
    end else begin
      ram_cmd_en <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      case (state)
        IDLE: begin
          if (!ram_busy && (req0_valid || req1_valid)) begin
            winner     <= pick;
            ptr        <= ~pick;
            ram_cmd_en <= 1'b1;
            ram_cmd    <= sel_write;
            ram_addr   <= sel_addr & LINE_MASK;
            if (sel_write) begin
              // Word 0 rides along with the command; the rest follow back to back.
              ram_wr_data   <= sel_wdata[DATA_WIDTH-1:0];
              ram_data_mask <= sel_wmask[MASK_WIDTH-1:0];
              beat          <= BEAT_W'(1);
              state         <= WR_BEAT;
            end else begin
              beat  <= '0;
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (ram_rd_data_valid) begin
            if (winner) rbuf1[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= ram_rd_data;
            else        rbuf0[int'(beat)*DATA_WIDTH +: DATA_WIDTH] <= ram_rd_data;
            beat <= beat + BEAT_W'(1);
            if (beat == LAST_BEAT) begin
              state <= DONE;
              done0 <= ~winner;
              done1 <= winner;
            end
          end
        end
        WR_BEAT: begin
          ram_wr_data   <= cur_wdata[int'(beat)*DATA_WIDTH +: DATA_WIDTH];
          ram_data_mask <= cur_wmask[int'(beat)*MASK_WIDTH +: MASK_WIDTH];
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= WR_DRAIN;
          end else begin
            beat <= beat + BEAT_W'(1);
          end
        end
        WR_DRAIN: begin
          if (!ram_busy) begin
            state <= DONE;
            done0 <= ~winner;
            done1 <= winner;
          end
        end
        DONE: begin
          // The winner's valid is still high here; it is not looked at until IDLE.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
